// File: rtl/run_control.sv
// Front-panel run/halt controller: conditions four raw push-buttons into one-clock
// events and sequences RUN/HALT/STEPI/STEPC so stops and steps land on strobe boundaries.
module run_control #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CK,
  input  logic CLEAR_N,
  input  logic SW_START,
  input  logic SW_STOP,
  input  logic SW_STEPI,
  input  logic SW_STEPC,
  input  logic HLT_INSTR,
  input  logic STB_LAST,
  input  logic STB_ANY,
  output logic RUN,
  output logic HALT,
  output logic STEPI,
  output logic STEPC,
  output logic RUN_LED
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam int EV_START = 0;
  localparam int EV_STOP  = 1;
  localparam int EV_STEPI = 2;
  localparam int EV_STEPC = 3;

  // State encoding doubles as the output vector {RUN, HALT, STEPI, STEPC},
  // so every output comes straight from a flop with no decode glitches.
  localparam logic [3:0] S_IDLE     = 4'b0100;
  localparam logic [3:0] S_RUNNING  = 4'b1000;
  localparam logic [3:0] S_STOPPING = 4'b1100;
  localparam logic [3:0] S_STEP_I   = 4'b1010;
  localparam logic [3:0] S_STEP_C   = 4'b1001;

  logic [3:0] raw;
  logic [3:0] ev;

  assign raw = {SW_STEPC, SW_STEPI, SW_STOP, SW_START};

  for (genvar i = 0; i < 4; i++) begin : g_sw
    logic          sync1;
    logic          sync2;
    logic          level;
    logic          pulse;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge CK or negedge CLEAR_N) begin
      if (!CLEAR_N) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        level <= 1'b0;
        pulse <= 1'b0;
        cnt   <= '0;
      end else begin
        sync1 <= raw[i];
        sync2 <= sync1;
        pulse <= 1'b0;
        if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          // Accept the new level; only a press (0->1) produces an event.
          level <= sync2;
          pulse <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign ev[i] = pulse;
  end

  logic [3:0] state;
  logic [3:0] state_nxt;

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (ev[EV_STOP])       state_nxt = S_IDLE;
        else if (ev[EV_START]) state_nxt = S_RUNNING;
        else if (ev[EV_STEPI]) state_nxt = S_STEP_I;
        else if (ev[EV_STEPC]) state_nxt = S_STEP_C;
      end
      S_RUNNING: begin
        if (ev[EV_STOP] || HLT_INSTR) state_nxt = STB_LAST ? S_IDLE : S_STOPPING;
      end
      S_STOPPING: begin
        if (STB_LAST) state_nxt = S_IDLE;
      end
      S_STEP_I: begin
        if (STB_LAST)         state_nxt = S_IDLE;
        else if (ev[EV_STOP]) state_nxt = S_STOPPING;
      end
      S_STEP_C: begin
        if (STB_ANY || ev[EV_STOP]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge CLEAR_N) begin
    if (!CLEAR_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  assign {RUN, HALT, STEPI, STEPC} = state;
  assign RUN_LED = state[3];

endmodule

// File: tb/tb_run_control.sv
// Self-checking bench for run_control (DEBOUNCE_CYCLES=4): directed front-panel
// sequences, a per-cycle behavioural model, and literal spot checks.
module tb_run_control;

  localparam int D = 4;

  logic       CK = 1'b0;
  logic       CLEAR_N = 1'b0;
  logic [3:0] sw = 4'b0000;   // {STEPC, STEPI, STOP, START}
  logic       HLT_INSTR = 1'b0;
  logic       STB_LAST = 1'b0;
  logic       STB_ANY = 1'b0;
  logic       RUN, HALT, STEPI, STEPC, RUN_LED;

  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_STOP  = 4'b0010;
  localparam logic [3:0] B_STEPI = 4'b0100;
  localparam logic [3:0] B_STEPC = 4'b1000;

  // Expected {RUN, HALT, STEPI, STEPC}
  localparam logic [3:0] O_IDLE = 4'b0100;
  localparam logic [3:0] O_RUN  = 4'b1000;
  localparam logic [3:0] O_STOP = 4'b1100;
  localparam logic [3:0] O_SI   = 4'b1010;
  localparam logic [3:0] O_SC   = 4'b1001;

  int n_checks = 0;
  int n_fail   = 0;

  run_control #(.DEBOUNCE_CYCLES(D)) dut (
    .CK        (CK),
    .CLEAR_N   (CLEAR_N),
    .SW_START  (sw[0]),
    .SW_STOP   (sw[1]),
    .SW_STEPI  (sw[2]),
    .SW_STEPC  (sw[3]),
    .HLT_INSTR (HLT_INSTR),
    .STB_LAST  (STB_LAST),
    .STB_ANY   (STB_ANY),
    .RUN       (RUN),
    .HALT      (HALT),
    .STEPI     (STEPI),
    .STEPC     (STEPC),
    .RUN_LED   (RUN_LED)
  );

  initial forever #5 CK = ~CK;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUNNING, M_STOPPING, M_STEP_I, M_STEP_C} mstate_t;

  mstate_t      m_state = M_IDLE;
  logic [D+1:0] m_hist [4] = '{default: '0};  // bit k = raw sample taken k edges ago
  logic [3:0]   m_acc = 4'b0000;
  logic [3:0]   m_ev  = 4'b0000;

  function automatic logic [3:0] model_outs(input mstate_t s);
    case (s)
      M_RUNNING:  return O_RUN;
      M_STOPPING: return O_STOP;
      M_STEP_I:   return O_SI;
      M_STEP_C:   return O_SC;
      default:    return O_IDLE;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge CK or negedge CLEAR_N);
      if (!CLEAR_N) begin
        m_state = M_IDLE;
        m_acc   = '0;
        m_ev    = '0;
        for (int i = 0; i < 4; i++) m_hist[i] = '0;
      end else begin
        case (m_state)
          M_IDLE: begin
            if (m_ev[1])      m_state = M_IDLE;
            else if (m_ev[0]) m_state = M_RUNNING;
            else if (m_ev[2]) m_state = M_STEP_I;
            else if (m_ev[3]) m_state = M_STEP_C;
          end
          M_RUNNING:  if (m_ev[1] || HLT_INSTR) m_state = STB_LAST ? M_IDLE : M_STOPPING;
          M_STOPPING: if (STB_LAST) m_state = M_IDLE;
          M_STEP_I: begin
            if (STB_LAST)     m_state = M_IDLE;
            else if (m_ev[1]) m_state = M_STOPPING;
          end
          M_STEP_C:   if (STB_ANY || m_ev[1]) m_state = M_IDLE;
          default:    m_state = M_IDLE;
        endcase
        // A level is accepted once the synchronised input (raw delayed two
        // edges) has disagreed with it for D consecutive edges.
        for (int i = 0; i < 4; i++) begin
          m_hist[i] = {m_hist[i][D:0], sw[i]};
          m_ev[i] = 1'b0;
          if (!m_acc[i] && (&m_hist[i][D+1:2])) begin
            m_acc[i] = 1'b1;
            m_ev[i]  = 1'b1;
          end else if (m_acc[i] && !(|m_hist[i][D+1:2])) begin
            m_acc[i] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CK);
      check("cycle_outputs", {RUN, HALT, STEPI, STEPC}, model_outs(m_state));
      check("run_led", {3'b000, RUN_LED}, {3'b000, model_outs(m_state) >> 3});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CK);
    #2;
  endtask

  task automatic press(input logic [3:0] m);
    sw = sw | m;
    tick(D + 3);
  endtask

  task automatic let_go(input logic [3:0] m);
    sw = sw & ~m;
    tick(D + 4);
  endtask

  task automatic strobe(input logic hlt, input logic last, input logic any);
    HLT_INSTR = hlt;
    STB_LAST  = last;
    STB_ANY   = any;
    tick(1);
    HLT_INSTR = 1'b0;
    STB_LAST  = 1'b0;
    STB_ANY   = 1'b0;
  endtask

  function automatic logic [3:0] outs();
    return {RUN, HALT, STEPI, STEPC};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    tick(3);
    check("reset_held", outs(), O_IDLE);
    CLEAR_N = 1'b1;
    tick(2);
    check("reset_released", outs(), O_IDLE);

    // Debounce: a 3-clock glitch is ignored
    sw = B_START;
    tick(3);
    sw = 4'b0000;
    tick(10);
    check("glitch_ignored", outs(), O_IDLE);

    // Clean press: RUN rises exactly 7 clocks after the raw edge
    sw = B_START;
    tick(6);
    check("start_not_yet", {3'b000, RUN}, 4'b0000);
    tick(1);
    check("start_latency", outs(), O_RUN);
    tick(20);
    check("start_held", outs(), O_RUN);
    let_go(B_START);

    // Stop lands on the instruction boundary
    press(B_STOP);
    check("stopping", outs(), O_STOP);
    tick(4);
    check("stopping_wait", outs(), O_STOP);
    strobe(1'b0, 1'b1, 1'b1);
    check("stopped", outs(), O_IDLE);
    let_go(B_STOP);

    // HLT with STB_LAST in the same clock
    press(B_START);
    let_go(B_START);
    check("run_again", outs(), O_RUN);
    strobe(1'b1, 1'b1, 1'b1);
    check("hlt_with_last", outs(), O_IDLE);

    // HLT alone, then STB_LAST
    press(B_START);
    let_go(B_START);
    strobe(1'b1, 1'b0, 1'b0);
    check("hlt_alone", outs(), O_STOP);
    tick(3);
    strobe(1'b0, 1'b1, 1'b1);
    check("hlt_then_last", outs(), O_IDLE);

    // Single-instruction step
    press(B_STEPI);
    check("stepi_on", outs(), O_SI);
    let_go(B_STEPI);
    for (int k = 0; k < 3; k++) begin
      strobe(1'b0, 1'b0, 1'b1);
      tick(1);
    end
    check("stepi_any_ignored", outs(), O_SI);
    strobe(1'b1, 1'b0, 1'b1);
    check("stepi_hlt_ignored", outs(), O_SI);
    strobe(1'b0, 1'b1, 1'b1);
    check("stepi_done", outs(), O_IDLE);

    // Single-cycle step
    press(B_STEPC);
    check("stepc_on", outs(), O_SC);
    let_go(B_STEPC);
    strobe(1'b0, 1'b0, 1'b1);
    check("stepc_done", outs(), O_IDLE);

    // STOP during steps
    press(B_STEPI);
    let_go(B_STEPI);
    press(B_STOP);
    check("stepi_stop", outs(), O_STOP);
    let_go(B_STOP);
    strobe(1'b0, 1'b1, 1'b1);
    check("stepi_stop_done", outs(), O_IDLE);
    press(B_STEPC);
    let_go(B_STEPC);
    press(B_STOP);
    check("stepc_stop", outs(), O_IDLE);
    let_go(B_STOP);

    // Simultaneous-event priority in IDLE
    press(B_START | B_STOP);
    check("prio_stop_start", outs(), O_IDLE);
    let_go(B_START | B_STOP);
    press(B_START | B_STEPI);
    check("prio_start_stepi", outs(), O_RUN);
    let_go(B_START | B_STEPI);
    press(B_STOP);
    let_go(B_STOP);
    strobe(1'b0, 1'b1, 1'b1);
    press(B_STEPI | B_STEPC);
    check("prio_stepi_stepc", outs(), O_SI);
    let_go(B_STEPI | B_STEPC);

    // START while not IDLE is dropped
    press(B_START);
    check("start_dropped", outs(), O_SI);
    strobe(1'b0, 1'b1, 1'b1);
    check("start_not_queued", outs(), O_IDLE);
    let_go(B_START);

    // Asynchronous reset mid STEP_I
    press(B_STEPI);
    let_go(B_STEPI);
    @(posedge CK);
    #3;
    CLEAR_N = 1'b0;
    #1;
    check("async_reset", outs(), O_IDLE);
    tick(2);
    CLEAR_N = 1'b1;
    tick(3);
    check("after_reset", outs(), O_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
